// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_arb_pkg;

   localparam int unsigned DEF_DEPTH  = 1024;
   localparam int unsigned DEF_ADDR_W = 64;
   localparam int unsigned DEF_DATA_W = 64;

   localparam logic PORT_CPU    = 1'b0;
   localparam logic PORT_LOADER = 1'b1;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   function automatic logic [1:0] port_onehot(input logic port);
      logic [1:0] oh;
      if (port == PORT_CPU) begin
         oh = 2'b01;
      end else begin
         oh = 2'b10;
      end
      return oh;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response and memory-pin bundle between requesters, arbiter and memory.
interface dmem_arbiter_if
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) ();

   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0]        req_write;
   logic [ADDR_W-1:0] req_addr0;
   logic [ADDR_W-1:0] req_addr1;
   logic [DATA_W-1:0] req_wdata0;
   logic [DATA_W-1:0] req_wdata1;
   logic [1:0]        rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_read_data;
   logic              busy;

   modport slave (
      input  req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
      input  mem_read_data,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output mem_address, mem_write_data, mem_read, mem_write, busy
   );

   modport master (
      output req_valid, req_write, req_addr0, req_addr1, req_wdata0, req_wdata1,
      output mem_read_data,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  mem_address, mem_write_data, mem_read, mem_write, busy
   );

endinterface

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin picker: a tie goes to the port that did not win last.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] grant
);

   // One-hot grant from request vector and previous winner
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and one-cycle access sequencer for the single-port data memory.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic          clk,
   input  logic          reset,
   dmem_arbiter_if.slave bus
);

   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   state_e            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              cmd_port_q, cmd_port_d;
   logic              cmd_write_q, cmd_write_d;
   logic              cmd_in_range_q, cmd_in_range_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [1:0]        rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

   logic [1:0]        grant_s;
   logic [1:0]        req_ready_s;
   logic              sel_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_wdata_s;
   logic              sel_in_range_s;

   rr_arbiter2 u_rr (
      .req        (bus.req_valid),
      .last_grant (last_grant_q),
      .grant      (grant_s)
   );

   assign req_ready_s    = (state_q == IDLE && !reset) ? grant_s : 2'b00;
   assign sel_s          = grant_s[1] ? PORT_LOADER : PORT_CPU;
   assign sel_addr_s     = (sel_s == PORT_LOADER) ? bus.req_addr1 : bus.req_addr0;
   assign sel_wdata_s    = (sel_s == PORT_LOADER) ? bus.req_wdata1 : bus.req_wdata0;
   // Full-width compare: high address bits must not alias into the array
   assign sel_in_range_s = (sel_addr_s < DEPTH_A);

   // Next-state: accept in IDLE, issue strobes for one ACCESS cycle, then respond
   always_comb begin
      state_d          = state_q;
      last_grant_d     = last_grant_q;
      cmd_port_d       = cmd_port_q;
      cmd_write_d      = cmd_write_q;
      cmd_in_range_d   = cmd_in_range_q;
      mem_address_d    = mem_address_q;
      mem_write_data_d = mem_write_data_q;
      mem_read_d       = 1'b0;
      mem_write_d      = 1'b0;
      rsp_valid_d      = 2'b00;
      rsp_rdata_d      = rsp_rdata_q;
      rsp_err_d        = rsp_err_q;
      case (state_q)
         IDLE: begin
            if ((bus.req_valid & req_ready_s) != 2'b00) begin
               state_d          = ACCESS;
               last_grant_d     = sel_s;
               cmd_port_d       = sel_s;
               cmd_write_d      = bus.req_write[sel_s];
               cmd_in_range_d   = sel_in_range_s;
               mem_address_d    = sel_addr_s;
               mem_write_data_d = sel_wdata_s;
               mem_read_d       = !bus.req_write[sel_s] && sel_in_range_s;
               mem_write_d      = bus.req_write[sel_s] && sel_in_range_s;
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            state_d     = IDLE;
            rsp_valid_d = port_onehot(cmd_port_q);
            rsp_err_d   = !cmd_in_range_q;
            if (cmd_in_range_q && !cmd_write_q) begin
               rsp_rdata_d = bus.mem_read_data;
            end else begin
               rsp_rdata_d = {DATA_W{1'b0}};
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, command and response registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= IDLE;
         last_grant_q     <= PORT_LOADER;
         cmd_port_q       <= PORT_CPU;
         cmd_write_q      <= 1'b0;
         cmd_in_range_q   <= 1'b0;
         mem_address_q    <= {ADDR_W{1'b0}};
         mem_write_data_q <= {DATA_W{1'b0}};
         mem_read_q       <= 1'b0;
         mem_write_q      <= 1'b0;
         rsp_valid_q      <= 2'b00;
         rsp_rdata_q      <= {DATA_W{1'b0}};
         rsp_err_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         last_grant_q     <= last_grant_d;
         cmd_port_q       <= cmd_port_d;
         cmd_write_q      <= cmd_write_d;
         cmd_in_range_q   <= cmd_in_range_d;
         mem_address_q    <= mem_address_d;
         mem_write_data_q <= mem_write_data_d;
         mem_read_q       <= mem_read_d;
         mem_write_q      <= mem_write_d;
         rsp_valid_q      <= rsp_valid_d;
         rsp_rdata_q      <= rsp_rdata_d;
         rsp_err_q        <= rsp_err_d;
      end
   end

   assign bus.req_ready      = req_ready_s;
   assign bus.rsp_valid      = rsp_valid_q;
   assign bus.rsp_rdata      = rsp_rdata_q;
   assign bus.rsp_err        = rsp_err_q;
   assign bus.mem_address    = mem_address_q;
   assign bus.mem_write_data = mem_write_data_q;
   assign bus.mem_read       = mem_read_q;
   assign bus.mem_write      = mem_write_q;
   assign bus.busy           = (state_q == ACCESS);

endmodule
